// File: rtl/y_decode_stage_pkg.sv
// Shared constants for the decode stage and yAlu: widths, RV32 opcodes, ALU op codes.
// The ALU op encodings are consumed unchanged by yAlu and its bench.
package y_decode_stage_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RIDX = $clog2(NREG);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/y_regfile.sv
// 32x32 register file: two asynchronous read ports with write-through bypass,
// one synchronous write port, x0 hardwired to zero.
module y_regfile
    import y_decode_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [RIDX-1:0] rs1_addr,
    input  logic [RIDX-1:0] rs2_addr,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    input  logic            wb_en,
    input  logic [RIDX-1:0] wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [NREG];
    logic            wb_live;

    assign wb_live = wb_en && (wb_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Bypass lets a same-cycle writeback reach an instruction being captured.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_addr != '0) begin
            rs1_val = (wb_live && wb_addr == rs1_addr) ? wb_data : regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_val = (wb_live && wb_addr == rs2_addr) ? wb_data : regs[rs2_addr];
        end
    end

endmodule

// File: rtl/y_decode_stage.sv
// RV32 subset decode stage feeding yAlu: register read, immediate build,
// control decode, and a registered ID/EX bundle behind a valid/ready handshake.
module y_decode_stage
    import y_decode_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_alu_op,
    output logic            out_alu_src,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_reg_wr,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_val, rs2_val, imm;
    alu_op_e         alu_op;
    logic            alu_src, mem_rd, mem_wr, reg_wr, branch, jump, illegal;
    logic            accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    y_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (in_instr[19:15]),
        .rs2_addr (in_instr[24:20]),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always_comb begin
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        reg_wr  = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        illegal = 1'b1;
        imm     = '0;
        case (opcode)
            OP_R: begin
                // Only funct7 = 0000000 / 0100000 exist in this subset.
                if ((funct7 & 7'b1011111) == 7'b0) begin
                    case ({funct3, funct7[5]})
                        4'b0000: begin alu_op = ALU_ADD; illegal = 1'b0; end
                        4'b0001: begin alu_op = ALU_SUB; illegal = 1'b0; end
                        4'b0100: begin alu_op = ALU_SLT; illegal = 1'b0; end
                        4'b1100: begin alu_op = ALU_OR;  illegal = 1'b0; end
                        4'b1110: begin alu_op = ALU_AND; illegal = 1'b0; end
                        default: alu_op = ALU_ADD;
                    endcase
                    reg_wr = !illegal;
                end
            end
            OP_IMM: begin
                imm = {{20{in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b000: begin alu_op = ALU_ADD; illegal = 1'b0; end
                    3'b010: begin alu_op = ALU_SLT; illegal = 1'b0; end
                    3'b110: begin alu_op = ALU_OR;  illegal = 1'b0; end
                    3'b111: begin alu_op = ALU_AND; illegal = 1'b0; end
                    default: alu_op = ALU_ADD;
                endcase
                alu_src = !illegal;
                reg_wr  = !illegal;
            end
            OP_LOAD: begin
                imm = {{20{in_instr[31]}}, in_instr[31:20]};
                if (funct3 == 3'b010) begin
                    illegal = 1'b0;
                    alu_src = 1'b1;
                    mem_rd  = 1'b1;
                    reg_wr  = 1'b1;
                end
            end
            OP_STORE: begin
                imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                if (funct3 == 3'b010) begin
                    illegal = 1'b0;
                    alu_src = 1'b1;
                    mem_wr  = 1'b1;
                end
            end
            OP_BRANCH: begin
                imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    illegal = 1'b0;
                    alu_op  = ALU_SUB;
                    branch  = 1'b1;
                end
            end
            OP_JAL: begin
                imm     = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
                illegal = 1'b0;
                jump    = 1'b1;
                reg_wr  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_alu_op  <= '0;
            out_alu_src <= 1'b0;
            out_mem_rd  <= 1'b0;
            out_mem_wr  <= 1'b0;
            out_reg_wr  <= 1'b0;
            out_branch  <= 1'b0;
            out_jump    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_imm     <= imm;
            out_rd      <= reg_wr ? in_instr[11:7] : 5'd0;
            out_alu_op  <= alu_op;
            out_alu_src <= alu_src;
            out_mem_rd  <= mem_rd;
            out_mem_wr  <= mem_wr;
            out_reg_wr  <= reg_wr;
            out_branch  <= branch;
            out_jump    <= jump;
            out_illegal <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_y_decode_stage.sv
// Directed bench for y_decode_stage: hand-decoded RV32 vectors, stall/bypass/reset cases.
module tb_y_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic [2:0]  out_alu_op;
    logic        out_alu_src, out_mem_rd, out_mem_wr, out_reg_wr;
    logic        out_branch, out_jump, out_illegal;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    y_decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_reg_wr(out_reg_wr),
        .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_alu_op", out_alu_op, 0);

        rst = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h7;
        step();
        wb_en = 1'b0;
        check("idle_in_ready", in_ready, 1);

        // ADD x3,x5,x5
        issue(32'h005281B3, 32'h100);
        step();
        check("add_valid", out_valid, 1);
        check("add_pc", out_pc, 32'h100);
        check("add_rs1", out_rs1_val, 32'h7);
        check("add_rs2", out_rs2_val, 32'h7);
        check("add_op", out_alu_op, 3'b010);
        check("add_rd", out_rd, 3);
        check("add_reg_wr", out_reg_wr, 1);
        check("add_alu_src", out_alu_src, 0);

        // SUB x4,x5,x6 with x6 written in the capture cycle
        issue(32'h40628233, 32'h104);
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hFFFF_FFFF;
        step();
        wb_en = 1'b0;
        check("sub_rs1", out_rs1_val, 32'h7);
        check("sub_rs2_bypass", out_rs2_val, 32'hFFFF_FFFF);
        check("sub_op", out_alu_op, 3'b110);
        check("sub_rd", out_rd, 4);

        // SW x2,-4(x1)
        issue(32'hFE20AE23, 32'h108);
        step();
        check("sw_imm", out_imm, 32'hFFFF_FFFC);
        check("sw_mem_wr", out_mem_wr, 1);
        check("sw_reg_wr", out_reg_wr, 0);
        check("sw_rd", out_rd, 0);
        check("sw_alu_src", out_alu_src, 1);
        check("sw_op", out_alu_op, 3'b010);
        check("sw_rs1", out_rs1_val, 0);

        // stall with BEQ pending; x1 written meanwhile must not refresh the held SW bundle
        out_ready = 1'b0;
        issue(32'hFE208CE3, 32'h10C);
        #1;
        check("stall_in_ready", in_ready, 0);
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            wb_en = 1'b0;
            check("stall_in_ready_hold", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_pc", out_pc, 32'h108);
            check("stall_rs1", out_rs1_val, 0);
            check("stall_imm", out_imm, 32'hFFFF_FFFC);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        step();
        check("beq_pc", out_pc, 32'h10C);
        check("beq_branch", out_branch, 1);
        check("beq_imm", out_imm, 32'hFFFF_FFF8);
        check("beq_op", out_alu_op, 3'b110);
        check("beq_rs1", out_rs1_val, 32'h55);
        check("beq_rd", out_rd, 0);
        check("beq_alu_src", out_alu_src, 0);

        // JAL x1,+0x800
        issue(32'h001000EF, 32'h110);
        step();
        check("jal_pc", out_pc, 32'h110);
        check("jal_jump", out_jump, 1);
        check("jal_imm", out_imm, 32'h800);
        check("jal_rd", out_rd, 1);
        check("jal_op", out_alu_op, 3'b010);

        // SLTI x2,x1,-1
        issue(32'hFFF0A113, 32'h114);
        step();
        check("slti_op", out_alu_op, 3'b111);
        check("slti_imm", out_imm, 32'hFFFF_FFFF);
        check("slti_rs1", out_rs1_val, 32'h55);
        check("slti_rd", out_rd, 2);
        check("slti_alu_src", out_alu_src, 1);

        in_valid = 1'b0;
        step();
        check("bubble_valid", out_valid, 0);

        // x0 write is ignored, both stored and bypassed
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        step();
        issue(32'h00500093, 32'h118);
        step();
        wb_en = 1'b0;
        check("addi_rs1_x0", out_rs1_val, 0);
        check("addi_imm", out_imm, 5);
        check("addi_rd", out_rd, 1);
        check("addi_alu_src", out_alu_src, 1);

        // XOR is outside the subset
        issue(32'h0062C1B3, 32'h11C);
        step();
        check("xor_valid", out_valid, 1);
        check("xor_illegal", out_illegal, 1);
        check("xor_reg_wr", out_reg_wr, 0);
        check("xor_op", out_alu_op, 3'b010);
        check("xor_rd", out_rd, 0);

        // reset with a held bundle
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("mrst_valid", out_valid, 0);
        check("mrst_pc", out_pc, 0);
        check("mrst_illegal", out_illegal, 0);
        check("mrst_in_ready", in_ready, 0);
        rst = 1'b0;
        issue(32'h005281B3, 32'h120);
        step();
        in_valid = 1'b0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_x5", out_rs1_val, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/y_decode_stage.md
Name: y_decode_stage

Overview:
- Instruction-decode stage sitting directly upstream of the 32-bit ALU (yAlu).
- Accepts a fetched RV32 instruction and PC over a valid/ready handshake.
- Reads the 32x32 register file, builds the immediate, and derives the 3-bit ALU op plus control flags.
- Presents everything in a registered ID/EX bundle; the register file write port is driven by the writeback stage.

Parameters:
- XLEN, 32, datapath width; fixed for the yAlu interface.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction/PC valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  RV32 instruction word.
- in_pc  in  32  PC of in_instr.
- wb_en  in  1  register-file write enable.
- wb_addr  in  5  write index.
- wb_data  in  32  write data.
- out_valid  out  1  ID/EX bundle valid.
- out_ready  in  1  ALU stage accepts the bundle.
- out_pc  out  32  registered PC.
- out_rs1_val  out  32  rs1 operand.
- out_rs2_val  out  32  rs2 operand.
- out_imm  out  32  sign-extended immediate.
- out_rd  out  5  destination index.
- out_alu_op  out  3  yAlu op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- out_alu_src  out  1  1 selects imm as ALU operand b.
- out_mem_rd, out_mem_wr, out_reg_wr, out_branch, out_jump, out_illegal  out  1 each  control flags.

Behaviour:
- Reset: all registers in the register file clear to 0 in that single cycle. out_valid=0 and every out_* field is 0. in_ready is 0 during rst.
- Reset asserted mid-operation discards the held bundle; no partial state survives.
- Handshake:
  - in_ready = !rst && (!out_valid || out_ready).
  - Capture occurs when in_valid && in_ready; out_valid=1 on the next edge with a latency of 1 cycle.
  - When out_valid && !out_ready, all out_* fields hold stable.
  - Bubble: out_valid clears when out_ready && !(in_valid && in_ready).
  - A back-to-back capture/consume pair in the same cycle sustains one instruction per cycle.
- Register file:
  - Asynchronous read at rs1=instr[19:15] and rs2=instr[24:20].
  - Write on edge when wb_en && wb_addr!=0; writes to x0 are ignored and x0 always reads 0.
  - Same-cycle bypass: if wb_en && wb_addr==rsN && rsN!=0, the captured value is wb_data.
  - Writeback is independent of the handshake; it occurs even while the stage is stalled.
  - A stalled bundle is not refreshed; the value captured at accept is final.
- Immediates (sign bit instr[31]):
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Decode by opcode:
  - 0110011 R, with funct3/funct7[5]:
    - 000/0 gives add; 000/1 gives sub.
    - 010/0 gives slt.
    - 110/0 gives or.
    - 111/0 gives and.
    - reg_wr=1, alu_src=0.
  - 0010011 I-ALU: funct3 000 add, 010 slt, 110 or, 111 and; alu_src=1, reg_wr=1.
  - 0000011 with funct3=010 (LW): add, alu_src=1, mem_rd=1, reg_wr=1.
  - 0100011 with funct3=010 (SW): add, alu_src=1, mem_wr=1.
  - 1100011 with funct3 000/001 (BEQ/BNE): sub, alu_src=0, branch=1; the downstream stage uses yAlu ex (zero flag).
  - 1101111 (JAL): add, jump=1, reg_wr=1, imm=J.
  - Any other opcode/funct3/funct7 combination: illegal=1, every other control flag 0, alu_op=010. The bundle is still issued as valid.
- out_rd is forced to 0 whenever reg_wr=0.

Decomposition:
- Shared package: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL) and ALU op codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT). These same codes are consumed by yAlu and its testbench.
- One sub-module: y_regfile (32x32, 2 asynchronous read ports, 1 synchronous write port, synchronous reset, write-through bypass). Decode and immediate logic remain in the top module.

Test Plan:
- Reset, then write x5=0x00000007 via wb; accept ADD x3,x5,x5 (0x005281B3) -> next cycle out_valid=1, rs1=rs2=7, alu_op=010, rd=3, reg_wr=1, alu_src=0.
- Accept SUB (0x40628233) while wb_en writes x6=0xFFFFFFFF in the same cycle -> out_rs2_val=0xFFFFFFFF via bypass, alu_op=110.
- Accept SW x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFC, mem_wr=1, reg_wr=0, rd=0, alu_src=1, alu_op=010.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; raise out_ready -> the next instruction is captured on that edge with no loss or duplication.
- wb writes x0=0x1234, then accept ADDI x1,x0,5 (0x00500093) -> rs1=0, imm=5; also assert rst while out_valid=1 -> next cycle out_valid=0 and x5 reads 0.
- Accept XOR (0x0062C1B3) -> illegal=1, reg_wr=0, alu_op=010, out_valid=1.
